// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: FSM states, field widths
// and the bit positions inside the 6-bit ALU flag vector.
package alu_ctrl_pkg;

    localparam int CMD_W       = 4;
    localparam int INP_VALID_W = 2;
    localparam int FLAG_W      = 6;

    // Flag vector layout {COUT, OFLOW, G, E, L, ERR}
    localparam int FLAG_COUT  = 5;
    localparam int FLAG_OFLOW = 4;
    localparam int FLAG_G     = 3;
    localparam int FLAG_E     = 2;
    localparam int FLAG_L     = 1;
    localparam int FLAG_ERR   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin choice: a lone requester always wins; on contention the
// requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; last=1 means requester 1 was served last, so 0 is favoured
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters. One operation is in
// flight at a time: IDLE (grant) -> ISSUE -> WAIT x LAT -> RESP -> IDLE.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [2*WIDTH-1:0]       req_opa,
    input  logic [2*WIDTH-1:0]       req_opb,
    input  logic [1:0]               req_cin,
    input  logic [1:0]               req_mode,
    input  logic [2*CMD_W-1:0]       req_cmd,
    input  logic [2*INP_VALID_W-1:0] req_inp_valid,
    output logic [WIDTH-1:0]         alu_opa,
    output logic [WIDTH-1:0]         alu_opb,
    output logic                     alu_cin,
    output logic                     alu_mode,
    output logic                     alu_ce,
    output logic [CMD_W-1:0]         alu_cmd,
    output logic [INP_VALID_W-1:0]   alu_inp_valid,
    input  logic [2*WIDTH-1:0]       alu_res,
    input  logic [FLAG_W-1:0]        alu_flags,
    output logic [1:0]               rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_res,
    output logic [FLAG_W-1:0]        rsp_flags,
    output logic                     busy
);

    state_t     state;
    logic [3:0] cnt;
    logic       last;     // id of the requester served most recently
    logic       owner;    // id of the requester whose op is in flight
    logic [1:0] grant;
    logic       win_id;
    logic       hs;

    rr_arb2 u_arb (
        .req   (req_valid),
        .last  (last),
        .grant (grant)
    );

    // Grant is offered only in IDLE; gated by rst since the async reset holds IDLE
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !rst)
            req_ready = grant;
    end

    assign win_id = grant[1];
    assign hs     = |(req_valid & req_ready);

    // Main control FSM; every output except req_ready is registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            last          <= 1'b1;
            owner         <= 1'b0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_cin       <= 1'b0;
            alu_mode      <= 1'b0;
            alu_cmd       <= '0;
            alu_ce        <= 1'b0;
            alu_inp_valid <= '0;
            rsp_valid     <= 2'b00;
            rsp_res       <= '0;
            rsp_flags     <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        owner         <= win_id;
                        alu_opa       <= win_id ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
                        alu_opb       <= win_id ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
                        alu_cin       <= win_id ? req_cin[1]  : req_cin[0];
                        alu_mode      <= win_id ? req_mode[1] : req_mode[0];
                        alu_cmd       <= win_id ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
                        alu_inp_valid <= win_id ? req_inp_valid[2*INP_VALID_W-1:INP_VALID_W]
                                                : req_inp_valid[INP_VALID_W-1:0];
                        alu_ce        <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 4'(LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        // ALU result is valid on this edge; capture and release the ALU
                        rsp_res       <= alu_res;
                        rsp_flags     <= alu_flags;
                        rsp_valid     <= owner ? 2'b10 : 2'b01;
                        alu_ce        <= 1'b0;
                        alu_inp_valid <= '0;
                        cnt           <= 4'd0;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    last      <= owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
